fpu_arbiter: RTL and testbench
==============================

FPU_ARBITER -- requirements
Module: fpu_arbiter

Parameters
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of model managers sharing one FPU (2..8).
REQ-002 The block SHALL have parameter OP_W, default 4: width of the FPU opcode (op_id).
REQ-003 The block SHALL have parameter HND_W, default 64: width of one mem_handle_t, {region_begin, region_end}.
REQ-004 The block SHALL have parameter TIMEOUT, default 65535: maximum FPU busy cycles, 16-bit.

Interface
REQ-005 The block SHALL have port `clk`, input, 1 bit: the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port `rst`, input, 1 bit: the reset, asynchronous and active-high.
REQ-007 The block SHALL have port `req`, input, NUM_REQ bits: per-requester fpu_avail level.
REQ-008 The block SHALL have port `req_op`, input, NUM_REQ*OP_W bits: per-requester opcode.
REQ-009 The block SHALL have ports `req_a`, `req_b`, `req_c` and `req_d`, input, NUM_REQ*HND_W bits each: per-requester operand and result handles.
REQ-010 The block SHALL have port `grant`, output, NUM_REQ bits: one-hot owner of the FPU.
REQ-011 The block SHALL have port `req_done`, output, NUM_REQ bits: one-cycle completion pulse to the owner.
REQ-012 The block SHALL have port `fpu_start`, output, 1 bit: one-cycle launch pulse to the FPU.
REQ-013 The block SHALL have port `fpu_op`, output, OP_W bits: latched opcode.
REQ-014 The block SHALL have ports `fpu_a`, `fpu_b`, `fpu_c` and `fpu_d`, output, HND_W bits each: latched handles.
REQ-015 The block SHALL have port `fpu_done`, input, 1 bit: FPU completion pulse.
REQ-016 The block SHALL have port `busy`, output, 1 bit: high in any state other than IDLE.
REQ-017 The block SHALL have port `err_timeout`, output, 1 bit: sticky flag for an FPU timeout.
REQ-018 The block SHALL have port `err_spurious`, output, 1 bit: sticky flag for an fpu_done received outside WAIT.

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, WAIT, RELEASE and HOLD, encoded in 3 bits.
REQ-020 In IDLE with req != 0, the block SHALL select the winner by round-robin starting at index ptr and searching upward modulo NUM_REQ.
REQ-021 On that same edge the block SHALL register grant as one-hot of the winner, latch the winner's op and a/b/c/d into fpu_*, set ptr to (winner+1) mod NUM_REQ, and go to ISSUE.
REQ-022 In IDLE with req == 0, the block SHALL keep its state, and grant and ptr SHALL be unchanged.
REQ-023 In ISSUE, fpu_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT.
REQ-024 Latency SHALL be: req rising in IDLE at cycle N gives fpu_start high in cycle N+1.
REQ-025 fpu_op and fpu_a..d SHALL be stable from ISSUE through HOLD; the requester's inputs are not re-sampled during that time.
REQ-026 In WAIT, a 16-bit counter SHALL be cleared on entry and increment each cycle.
REQ-027 In WAIT, fpu_done=1 SHALL move the block to RELEASE.
REQ-028 In WAIT, if the counter reaches TIMEOUT without fpu_done, the block SHALL set err_timeout and move to RELEASE.
REQ-029 In RELEASE, req_done SHALL equal grant for exactly one cycle, and the next state SHALL be HOLD.
REQ-030 In HOLD, all req SHALL be ignored for one cycle; grant SHALL clear to 0 on exit, and the next state SHALL be IDLE. This covers the requester's one-cycle lag in dropping fpu_avail.
REQ-031 fpu_done sampled in IDLE, ISSUE, RELEASE or HOLD SHALL be ignored for sequencing and SHALL set err_spurious.
REQ-032 If the owner drops req before completion, the operation SHALL still run to completion and req_done SHALL still pulse.
REQ-033 fpu_done and timeout in the same cycle SHALL be treated as a normal completion, with err_timeout left unchanged.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 The error flags SHALL stay set until rst.

Reset
REQ-036 While rst=1, asynchronously: state SHALL be IDLE; ptr, the counter, grant, req_done, fpu_start, fpu_op, fpu_a..d, busy, err_timeout and err_spurious SHALL all be 0.
REQ-037 rst asserted mid-operation SHALL abort with no req_done pulse; after rst deasserts, arbitration SHALL restart from ptr=0.

Verification
REQ-038 Verification: with NUM_REQ=4, req=4'b0100 with op=3 and a=0x0000000A_00000014, fpu_done 5 cycles after fpu_start -> fpu_start in cycle 1, fpu_op=3, fpu_a=0x0000000A_00000014, req_done=4'b0100 in the cycle after fpu_done, grant=0 in the cycle after HOLD.
REQ-039 Verification: req=4'b1111 held, each requester dropping req 1 cycle after its req_done -> grant order 0,1,2,3,0 and no requester granted twice in a row.
REQ-040 Verification: TIMEOUT=8, fpu_done never asserted -> RELEASE after 8 WAIT cycles, err_timeout=1, req_done pulses.
REQ-041 Verification: fpu_done pulsed while in IDLE -> err_spurious=1, no state change, no grant.
REQ-042 Verification: rst pulsed during WAIT for owner 2 -> all outputs 0 at once, no req_done; with req=4'b0110 after reset, grant=4'b0010.
REQ-043 Verification: owner drops req during WAIT -> fpu_op and fpu_a..d unchanged, and req_done still pulses on fpu_done.

Source files
------------

// File: rtl/fpu_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : fpu_arbiter
// Description : Round-robin arbiter that lets NUM_REQ model managers share a
//               single FPU. A winning requester's opcode and four memory
//               handles are latched and launched to the FPU with a one-cycle
//               start pulse. The arbiter then waits for the FPU's done pulse,
//               bounded by a watchdog, and returns a one-cycle completion
//               pulse to the owner. A one-cycle HOLD state absorbs the
//               requester's lag in dropping its request.
//
// Ports       : clk          - clock, rising edge
//               rst          - asynchronous active-high reset
//               req          - per-requester request level (fpu_avail)
//               req_op       - per-requester opcode, packed NUM_REQ x OP_W
//               req_a..req_d - per-requester handles, packed NUM_REQ x HND_W
//               grant        - one-hot current owner of the FPU
//               req_done     - one-cycle completion pulse to the owner
//               fpu_start    - one-cycle launch pulse to the FPU
//               fpu_op       - latched opcode
//               fpu_a..fpu_d - latched handles
//               fpu_done     - FPU completion pulse
//               busy         - arbiter is not idle
//               err_timeout  - sticky: FPU exceeded TIMEOUT busy cycles
//               err_spurious - sticky: fpu_done seen outside WAIT
//
// Revision    : 1.0 - initial release
//==============================================================================
module fpu_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int OP_W    = 4,
    parameter int HND_W   = 64,
    parameter int TIMEOUT = 65535
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*OP_W-1:0]  req_op,
    input  logic [NUM_REQ*HND_W-1:0] req_a,
    input  logic [NUM_REQ*HND_W-1:0] req_b,
    input  logic [NUM_REQ*HND_W-1:0] req_c,
    input  logic [NUM_REQ*HND_W-1:0] req_d,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       req_done,
    output logic                     fpu_start,
    output logic [OP_W-1:0]          fpu_op,
    output logic [HND_W-1:0]         fpu_a,
    output logic [HND_W-1:0]         fpu_b,
    output logic [HND_W-1:0]         fpu_c,
    output logic [HND_W-1:0]         fpu_d,
    input  logic                     fpu_done,
    output logic                     busy,
    output logic                     err_timeout,
    output logic                     err_spurious
);

    //--------------------------------------------------------------------------
    // Constants
    //--------------------------------------------------------------------------
    localparam int                   c_ptr_w    = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0]   c_one      = {{(NUM_REQ-1){1'b0}}, 1'b1};
    localparam logic [c_ptr_w-1:0]   c_last_idx = c_ptr_w'(NUM_REQ - 1);
    // Last counter value inside WAIT; reaching it without fpu_done means the
    // FPU has been busy for TIMEOUT cycles.
    localparam logic [15:0]          c_tmo_last = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_HOLD    = 3'd4
    } state_t;

    //--------------------------------------------------------------------------
    // Registers
    //--------------------------------------------------------------------------
    state_t               r_state;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [15:0]          r_wait_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [OP_W-1:0]      r_op;
    logic [HND_W-1:0]     r_a;
    logic [HND_W-1:0]     r_b;
    logic [HND_W-1:0]     r_c;
    logic [HND_W-1:0]     r_d;
    logic                 r_err_timeout;
    logic                 r_err_spurious;

    //--------------------------------------------------------------------------
    // Combinational signals
    //--------------------------------------------------------------------------
    state_t               w_state_nxt;
    logic                 w_any_req;
    logic [NUM_REQ-1:0]   w_hi_mask;
    logic [NUM_REQ-1:0]   w_req_hi;
    logic [NUM_REQ-1:0]   w_pick_src;
    logic [c_ptr_w-1:0]   w_win_idx;
    logic [c_ptr_w-1:0]   w_ptr_nxt;
    logic [NUM_REQ-1:0]   w_grant_nxt;
    logic [OP_W-1:0]      w_sel_op;
    logic [HND_W-1:0]     w_sel_a;
    logic [HND_W-1:0]     w_sel_b;
    logic [HND_W-1:0]     w_sel_c;
    logic [HND_W-1:0]     w_sel_d;
    logic                 w_timeout_hit;

    //--------------------------------------------------------------------------
    // Round-robin winner selection
    //
    // Requests at or above ptr are searched first; if there are none the
    // search wraps to the lowest-numbered request. Taking the lowest set bit
    // of the chosen vector is therefore the same as searching upward from ptr
    // modulo NUM_REQ, and works for non-power-of-two NUM_REQ.
    //--------------------------------------------------------------------------
    assign w_any_req  = |req;
    assign w_hi_mask  = ~((c_one << r_ptr) - c_one);
    assign w_req_hi   = req & w_hi_mask;
    assign w_pick_src = (|w_req_hi) ? w_req_hi : req;

    always_comb begin
        w_win_idx = '0;
        w_sel_op  = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_c   = '0;
        w_sel_d   = '0;
        // Walk downward so the lowest set bit is the final assignment.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (w_pick_src[i]) begin
                w_win_idx = c_ptr_w'(i);
                w_sel_op  = req_op[i*OP_W +: OP_W];
                w_sel_a   = req_a[i*HND_W +: HND_W];
                w_sel_b   = req_b[i*HND_W +: HND_W];
                w_sel_c   = req_c[i*HND_W +: HND_W];
                w_sel_d   = req_d[i*HND_W +: HND_W];
            end
        end
    end

    assign w_grant_nxt = c_one << w_win_idx;
    assign w_ptr_nxt   = (w_win_idx == c_last_idx) ? '0 : (w_win_idx + c_ptr_w'(1));

    assign w_timeout_hit = (r_wait_cnt == c_tmo_last);

    //--------------------------------------------------------------------------
    // FSM: state register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    //--------------------------------------------------------------------------
    // FSM: next-state logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_req) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A done pulse coinciding with the watchdog limit is a normal
                // completion, so both paths lead to RELEASE.
                if (fpu_done || w_timeout_hit) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    //--------------------------------------------------------------------------
    // Datapath: grant, pointer, latched operation, watchdog, error flags
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr          <= '0;
            r_wait_cnt     <= '0;
            r_grant        <= '0;
            r_op           <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_c            <= '0;
            r_d            <= '0;
            r_err_timeout  <= 1'b0;
            r_err_spurious <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The operation is captured only here, so fpu_* stay
                    // stable for the whole ISSUE..HOLD window regardless of
                    // what the requester does with its inputs.
                    if (w_any_req) begin
                        r_grant <= w_grant_nxt;
                        r_ptr   <= w_ptr_nxt;
                        r_op    <= w_sel_op;
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_c     <= w_sel_c;
                        r_d     <= w_sel_d;
                    end
                end
                ST_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (!fpu_done) begin
                        if (w_timeout_hit) begin
                            r_err_timeout <= 1'b1;
                        end else begin
                            r_wait_cnt <= r_wait_cnt + 16'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    r_grant <= '0;
                end
                default: begin
                end
            endcase

            // Any done pulse not expected by the sequencer is flagged.
            if (fpu_done && (r_state != ST_WAIT)) begin
                r_err_spurious <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    assign grant        = r_grant;
    assign req_done     = (r_state == ST_RELEASE) ? r_grant : '0;
    assign fpu_start    = (r_state == ST_ISSUE);
    assign fpu_op       = r_op;
    assign fpu_a        = r_a;
    assign fpu_b        = r_b;
    assign fpu_c        = r_c;
    assign fpu_d        = r_d;
    assign busy         = (r_state != ST_IDLE);
    assign err_timeout  = r_err_timeout;
    assign err_spurious = r_err_spurious;

endmodule
`default_nettype wire

// File: tb/tb_fpu_arbiter.sv
`default_nettype none
//==============================================================================
// Module      : tb_fpu_arbiter
// Description : Self-checking bench for fpu_arbiter. Expected operations are
//               queued when a request is driven and popped when the arbiter
//               launches the FPU; the bench also acts as the FPU.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_fpu_arbiter;

    localparam int NR  = 4;
    localparam int OPW = 4;
    localparam int HW  = 64;
    localparam int TMO = 8;

    logic                clk;
    logic                rst;
    logic [NR-1:0]       req;
    logic [NR*OPW-1:0]   req_op;
    logic [NR*HW-1:0]    req_a;
    logic [NR*HW-1:0]    req_b;
    logic [NR*HW-1:0]    req_c;
    logic [NR*HW-1:0]    req_d;
    logic [NR-1:0]       grant;
    logic [NR-1:0]       req_done;
    logic                fpu_start;
    logic [OPW-1:0]      fpu_op;
    logic [HW-1:0]       fpu_a;
    logic [HW-1:0]       fpu_b;
    logic [HW-1:0]       fpu_c;
    logic [HW-1:0]       fpu_d;
    logic                fpu_done;
    logic                busy;
    logic                err_timeout;
    logic                err_spurious;

    fpu_arbiter #(
        .NUM_REQ (NR),
        .OP_W    (OPW),
        .HND_W   (HW),
        .TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_op       (req_op),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_c        (req_c),
        .req_d        (req_d),
        .grant        (grant),
        .req_done     (req_done),
        .fpu_start    (fpu_start),
        .fpu_op       (fpu_op),
        .fpu_a        (fpu_a),
        .fpu_b        (fpu_b),
        .fpu_c        (fpu_c),
        .fpu_d        (fpu_d),
        .fpu_done     (fpu_done),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .err_spurious (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NR-1:0]  grant;
        logic [OPW-1:0] op;
        logic [HW-1:0]  a;
        logic [HW-1:0]  b;
        logic [HW-1:0]  c;
        logic [HW-1:0]  d;
    } exp_t;

    exp_t exp_q[$];
    int   m_ptr;
    int   vectors;
    int   miscompares;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int i, input logic [OPW-1:0] op,
                            input logic [HW-1:0] a, input logic [HW-1:0] b,
                            input logic [HW-1:0] c, input logic [HW-1:0] d);
        req_op[i*OPW +: OPW] = op;
        req_a[i*HW +: HW]    = a;
        req_b[i*HW +: HW]    = b;
        req_c[i*HW +: HW]    = c;
        req_d[i*HW +: HW]    = d;
    endtask

    task automatic fill_all();
        for (int i = 0; i < NR; i++) begin
            set_data(i, OPW'(i + 5), {32'(i + 1), 32'(16'hA000 + i)},
                     {32'(i + 2), 32'(16'hB000 + i)}, {32'(i + 3), 32'(16'hC000 + i)},
                     {32'(i + 4), 32'(16'hD000 + i)});
        end
    endtask

    // Reference round-robin: first requester at or above m_ptr, wrapping.
    task automatic push_expected(input logic [NR-1:0] mask, output int win);
        exp_t e;
        int   idx;
        win = -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (win < 0 && mask[idx]) win = idx;
        end
        m_ptr   = (win + 1) % NR;
        e.grant = NR'(1) << win;
        e.op    = req_op[win*OPW +: OPW];
        e.a     = req_a[win*HW +: HW];
        e.b     = req_b[win*HW +: HW];
        e.c     = req_c[win*HW +: HW];
        e.d     = req_d[win*HW +: HW];
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        req      = '0;
        fpu_done = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        exp_q.delete();
    endtask

    // Acts as the FPU for one operation. Called in an IDLE cycle with req
    // already driven; returns in the IDLE cycle that follows HOLD.
    // done_dly: cycles after fpu_start at which fpu_done is pulsed (-1 never).
    task automatic complete_op(input int done_dly, input int exp_rel,
                               input logic [NR-1:0] drop_in_hold,
                               input bit scramble, output logic [NR-1:0] got_grant);
        exp_t e;
        int   lat;
        int   c;
        bit   seen;
        got_grant = '0;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 6) begin
            tick();
            lat++;
            if (fpu_start === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen || lat != 1) begin
            miscompares++;
            $display("FAIL start_latency: got %0d cycles (seen=%0b), need 1", lat, seen);
        end
        if (!seen) return;
        got_grant = grant;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_empty: launch with grant %b, nothing expected", grant);
            return;
        end
        e = exp_q.pop_front();
        if (grant !== e.grant) begin
            miscompares++;
            $display("FAIL issue_grant: got %b, need %b", grant, e.grant);
        end
        vectors++;
        if ({fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== {e.op, e.a, e.b, e.c, e.d}) begin
            miscompares++;
            $display("FAIL issue_operands: got %h, need %h",
                     {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, {e.op, e.a, e.b, e.c, e.d});
        end

        c    = 0;
        seen = 1'b0;
        while (!seen && c < TMO + 6) begin
            tick();
            c++;
            fpu_done = 1'b0;
            if (c == 1) begin
                vectors++;
                if ({fpu_start, busy} !== 2'b01) begin
                    miscompares++;
                    $display("FAIL wait_entry: got start/busy %b, need 01", {fpu_start, busy});
                end
                if (scramble) begin
                    req    = '0;
                    req_op = ~req_op;
                    req_a  = ~req_a;
                    req_b  = ~req_b;
                    req_c  = ~req_c;
                    req_d  = ~req_d;
                end
            end
            if (req_done !== '0) seen = 1'b1;
            else if (c == done_dly) fpu_done = 1'b1;
        end
        vectors++;
        if (!seen || c != exp_rel) begin
            miscompares++;
            $display("FAIL release_timing: got req_done at +%0d (seen=%0b), need +%0d", c, seen, exp_rel);
        end
        vectors++;
        if (req_done !== e.grant) begin
            miscompares++;
            $display("FAIL req_done: got %b, need %b", req_done, e.grant);
        end
        vectors++;
        if ({fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== {e.op, e.a, e.b, e.c, e.d}) begin
            miscompares++;
            $display("FAIL operands_stable: got %h, need %h",
                     {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d}, {e.op, e.a, e.b, e.c, e.d});
        end

        req = req & ~drop_in_hold;
        tick();
        vectors++;
        if ({req_done, fpu_start, busy, grant} !== {{NR{1'b0}}, 1'b0, 1'b1, e.grant}) begin
            miscompares++;
            $display("FAIL hold: got done/start/busy/grant %b, need %b",
                     {req_done, fpu_start, busy, grant}, {{NR{1'b0}}, 1'b0, 1'b1, e.grant});
        end
        tick();
        vectors++;
        if ({grant, busy} !== {{NR{1'b0}}, 1'b0}) begin
            miscompares++;
            $display("FAIL idle_after_hold: got grant/busy %b, need 0", {grant, busy});
        end
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        req      = '0;
        fpu_done = 1'b0;
        req_op   = '0;
        req_a    = '0;
        req_b    = '0;
        req_c    = '0;
        req_d    = '0;
        #1 rst = 1'b1;
        #2;
        vectors++;
        if ({grant, req_done, fpu_start, busy, err_timeout, err_spurious} !== '0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, need 0",
                     {grant, req_done, fpu_start, busy, err_timeout, err_spurious});
        end
        vectors++;
        if ({fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h, need 0", {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d});
        end
        do_reset();
    endtask

    task automatic test_single();
        logic [NR-1:0] g;
        int            w;
        fill_all();
        set_data(2, 4'd3, 64'h0000000A_00000014, 64'h0000000B_0000001E,
                 64'h0000000C_00000028, 64'h0000000D_00000032);
        req = 4'b0100;
        push_expected(req, w);
        complete_op(5, 6, 4'b0100, 1'b0, g);
        vectors++;
        if ({g, fpu_op, fpu_a} !== {4'b0100, 4'd3, 64'h0000000A_00000014}) begin
            miscompares++;
            $display("FAIL single_op: got grant/op/a %h, need %h",
                     {g, fpu_op, fpu_a}, {4'b0100, 4'd3, 64'h0000000A_00000014});
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] order [5];
        logic [NR-1:0] g;
        logic [NR-1:0] prev;
        int            w;
        order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev  = '0;
        do_reset();
        fill_all();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            push_expected(req, w);
            complete_op(2 + k, 3 + k, NR'(1) << w, 1'b0, g);
            req = 4'b1111;
            vectors++;
            if (g !== order[k]) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got %b, need %b", k, g, order[k]);
            end
            if (k > 0) begin
                vectors++;
                if (g === prev) begin
                    miscompares++;
                    $display("FAIL rr_repeat[%0d]: got %b twice, need a different owner", k, g);
                end
            end
            prev = g;
        end
        req = '0;
    endtask

    task automatic test_done_at_limit();
        logic [NR-1:0] g;
        int            w;
        req = 4'b1000;
        push_expected(req, w);
        complete_op(1, 2, 4'b1000, 1'b0, g);
        req = 4'b1000;
        push_expected(req, w);
        complete_op(TMO, TMO + 1, 4'b1000, 1'b0, g);
        vectors++;
        if ({err_timeout, err_spurious} !== 2'b00) begin
            miscompares++;
            $display("FAIL done_at_limit_flags: got tmo/spur %b, need 00", {err_timeout, err_spurious});
        end
    endtask

    task automatic test_timeout();
        logic [NR-1:0] g;
        int            w;
        req = 4'b0010;
        push_expected(req, w);
        complete_op(-1, TMO + 1, 4'b0010, 1'b0, g);
        vectors++;
        if ({err_timeout, err_spurious} !== 2'b10) begin
            miscompares++;
            $display("FAIL timeout_flags: got tmo/spur %b, need 10", {err_timeout, err_spurious});
        end
    endtask

    task automatic test_spurious();
        req      = '0;
        fpu_done = 1'b1;
        tick();
        fpu_done = 1'b0;
        vectors++;
        if ({err_spurious, grant, busy, fpu_start} !== {1'b1, {NR{1'b0}}, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL spurious: got spur/grant/busy/start %b, need %b",
                     {err_spurious, grant, busy, fpu_start}, {1'b1, {NR{1'b0}}, 1'b0, 1'b0});
        end
        repeat (3) tick();
        vectors++;
        if ({err_timeout, err_spurious, busy} !== 3'b110) begin
            miscompares++;
            $display("FAIL sticky_flags: got tmo/spur/busy %b, need 110", {err_timeout, err_spurious, busy});
        end
    endtask

    task automatic test_drop_in_wait();
        logic [NR-1:0] g;
        int            w;
        fill_all();
        req = 4'b0100;
        push_expected(req, w);
        complete_op(3, 4, '0, 1'b1, g);
    endtask

    task automatic test_reset_mid();
        logic [NR-1:0] g;
        int            w;
        fill_all();
        req = 4'b0100;
        tick();
        vectors++;
        if ({fpu_start, grant} !== {1'b1, 4'b0100}) begin
            miscompares++;
            $display("FAIL mid_issue: got start/grant %b, need 10100", {fpu_start, grant});
        end
        tick();
        tick();
        rst = 1'b1;
        #1;
        vectors++;
        if ({grant, req_done, fpu_start, busy, err_timeout, err_spurious} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: got %b, need 0",
                     {grant, req_done, fpu_start, busy, err_timeout, err_spurious});
        end
        vectors++;
        if ({fpu_op, fpu_a, fpu_b, fpu_c, fpu_d} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_data: got %h, need 0", {fpu_op, fpu_a, fpu_b, fpu_c, fpu_d});
        end
        tick();
        vectors++;
        if ({req_done, grant} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_held: got done/grant %b, need 0", {req_done, grant});
        end
        @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        exp_q.delete();
        req = 4'b0110;
        push_expected(req, w);
        complete_op(2, 3, 4'b0110, 1'b0, g);
        vectors++;
        if (g !== 4'b0010) begin
            miscompares++;
            $display("FAIL restart_ptr: got %b, need 0010", g);
        end
        req = '0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ptr       = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_done_at_limit();
        test_timeout();
        test_spurious();
        test_drop_in_wait();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, need completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
